// File: rtl/spi_host_master.sv
// SPI mode-0 initiator: sends one command byte MSB first on MOSI and
// captures one response byte LSB first from MISO per transaction.
// All pins are registered and follow the FSM state by one clk cycle.
module spi_host_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       MISO,
    output logic       SCK,
    output logic       SS,
    output logic       MOSI,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    localparam int            CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_half_cnt;
    logic [2:0]    r_bit_cnt;
    logic          r_hold_ph;
    logic [7:0]    r_tx_sr;
    logic [7:0]    r_rx_sr;
    logic          r_sck;
    logic          r_ss;
    logic          r_mosi;
    logic [7:0]    r_rx_data;
    logic          r_rx_valid;
    logic          r_busy;
    logic          w_phase_end;
    logic          w_state_change;
    logic          w_sck_rise;
    logic          w_ss_active;

    assign w_phase_end    = (r_half_cnt == HALF_LAST);
    assign w_state_change = (w_state_next != r_state);
    // First cycle of HIGH is the edge on which SCK is driven 0 -> 1.
    assign w_sck_rise     = (r_state == S_HIGH) && (r_half_cnt == '0);
    assign w_ss_active    = (r_state != S_IDLE) && (r_state != S_DONE);

    // Next-state logic; HOLD spans two half-periods so SS stays low for a
    // full SCK period after the last falling edge.
    always_comb begin
        // NOTE: assign every always_comb output a default first so no path leaves it unassigned and infers a latch.
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_SETUP;
            S_SETUP: if (w_phase_end) w_state_next = S_HIGH;
            S_HIGH:  if (w_phase_end) w_state_next = (r_bit_cnt == 3'd7) ? S_HOLD : S_LOW;
            S_LOW:   if (w_phase_end) w_state_next = S_HIGH;
            S_HOLD:  if (w_phase_end && r_hold_ph) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_next;
        end
    end

    // Half-period counter, HOLD phase flag and bit counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_half_cnt <= '0;
            r_hold_ph  <= 1'b0;
            r_bit_cnt  <= 3'd0;
        end else begin
            if (r_state == S_IDLE || w_state_change || w_phase_end)
                r_half_cnt <= '0;
            else
                r_half_cnt <= r_half_cnt + CW'(1);

            r_hold_ph <= (r_state == S_HOLD) ? (r_hold_ph ^ w_phase_end) : 1'b0;

            if (r_state == S_IDLE)
                r_bit_cnt <= 3'd0;
            else if (r_state == S_HIGH && w_state_next == S_LOW)
                r_bit_cnt <= r_bit_cnt + 3'd1;
        end
    end

    // Transmit and receive shift registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_tx_sr <= 8'h00;
            r_rx_sr <= 8'h00;
        end else begin
            if (r_state == S_IDLE && start)
                r_tx_sr <= tx_data;
            else if (r_state == S_HIGH && w_state_next == S_LOW)
                r_tx_sr <= {r_tx_sr[6:0], 1'b0};

            if (w_sck_rise)
                r_rx_sr <= {MISO, r_rx_sr[7:1]};
        end
    end

    // Registered pin and status outputs derived from the current state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sck      <= 1'b0;
            r_ss       <= 1'b1;
            r_mosi     <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_sck      <= (r_state == S_HIGH);
            r_ss       <= ~w_ss_active;
            r_mosi     <= w_ss_active ? r_tx_sr[7] : 1'b0;
            r_rx_valid <= (r_state == S_DONE);
            r_busy     <= (r_state != S_IDLE);
            if (r_state == S_DONE)
                r_rx_data <= r_rx_sr;
        end
    end

    assign SCK      = r_sck;
    assign SS       = r_ss;
    assign MOSI     = r_mosi;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = r_busy;

endmodule

// File: tb/tb_spi_host_master.sv
// Bench for spi_host_master: one instance with CLK_DIV=4 and one with
// CLK_DIV=2, a behavioural SPI slave and a timing model built from the
// transaction formulas (rise k at 1+C*(1+2k), DONE at 1+18*C).
module tb_spi_host_master;

    logic       clk;
    logic       n_rst;
    logic       start_a, start_b;
    logic [7:0] tx_a, tx_b;
    logic       miso_a, miso_b;
    logic       sck_a, sck_b, ss_a, ss_b, mosi_a, mosi_b;
    logic [7:0] rxd_a, rxd_b;
    logic       rxv_a, rxv_b, busy_a, busy_b;

    int tests_run = 0;
    int tests_failed = 0;

    spi_host_master #(.CLK_DIV(4)) dut_a (
        .clk(clk), .n_rst(n_rst), .start(start_a), .tx_data(tx_a), .MISO(miso_a),
        .SCK(sck_a), .SS(ss_a), .MOSI(mosi_a), .rx_data(rxd_a), .rx_valid(rxv_a), .busy(busy_a)
    );

    spi_host_master #(.CLK_DIV(2)) dut_b (
        .clk(clk), .n_rst(n_rst), .start(start_b), .tx_data(tx_b), .MISO(miso_b),
        .SCK(sck_b), .SS(ss_b), .MOSI(mosi_b), .rx_data(rxd_b), .rx_valid(rxv_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         sel;       // 0: CLK_DIV=4 instance, 1: CLK_DIV=2 instance
        logic [7:0] tx;
        logic [7:0] resp;      // byte the bench slave returns
        int         poke;      // cycle to pulse start again (-1: none)
        bit         hold;      // keep start high after this transaction
        logic [7:0] exp_mosi;
        logic [7:0] exp_rx;
        int         exp_done;  // rx_valid cycle relative to acceptance edge
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic [7:0] tx, input logic mi);
        if (sel == 0) begin
            start_a = st; tx_a = tx; miso_a = mi;
        end else begin
            start_b = st; tx_b = tx; miso_b = mi;
        end
    endtask

    // One full transaction; called right after a negedge with the DUT idle
    // (or in its DONE cycle when start is being held). Observation n is the
    // negedge following acceptance edge t0+n.
    task automatic xfer(input int sel, input logic [7:0] tx, input logic [7:0] resp,
                        input int poke, input bit hold, input logic [7:0] exp_mosi,
                        input logic [7:0] exp_rx, input int exp_done);
        int         c, model_done, rises, falls, valid_cnt, valid_at;
        int         ss_err, busy_err, sck_err, time_err, hold_err, idle_err;
        logic [7:0] mosi_bits, rx_at_valid, prev_rx;
        logic       prev_sck, o_sck, o_ss, o_mosi, o_rxv, o_busy, cur_start, mi;
        logic [7:0] o_rxd, cur_tx;
        c = (sel == 0) ? 4 : 2;
        model_done = 1 + 18 * c;
        rises = 0; falls = 0; valid_cnt = 0; valid_at = -1;
        ss_err = 0; busy_err = 0; sck_err = 0; time_err = 0; hold_err = 0; idle_err = 0;
        mosi_bits = 8'h00; rx_at_valid = 8'h00;
        prev_rx  = (sel == 0) ? rxd_a : rxd_b;
        prev_sck = (sel == 0) ? sck_a : sck_b;
        cur_start = 1'b1; cur_tx = tx;
        drive(sel, cur_start, cur_tx, 1'($urandom));
        for (int n = 0; n <= exp_done; n++) begin
            @(negedge clk);
            o_sck  = (sel == 0) ? sck_a  : sck_b;
            o_ss   = (sel == 0) ? ss_a   : ss_b;
            o_mosi = (sel == 0) ? mosi_a : mosi_b;
            o_rxv  = (sel == 0) ? rxv_a  : rxv_b;
            o_busy = (sel == 0) ? busy_a : busy_b;
            o_rxd  = (sel == 0) ? rxd_a  : rxd_b;
            if (o_ss !== ((n >= 1 && n < model_done) ? 1'b0 : 1'b1)) ss_err++;
            if (o_busy !== ((n >= 1 && n <= model_done) ? 1'b1 : 1'b0)) busy_err++;
            if (o_sck === 1'b1 && o_ss === 1'b1) sck_err++;
            if (o_sck === 1'b1 && prev_sck === 1'b0) begin
                if (n != 1 + c * (1 + 2 * rises)) time_err++;
                if (rises < 8) mosi_bits[7 - rises] = o_mosi;
                rises++;
            end
            if (o_sck === 1'b0 && prev_sck === 1'b1) falls++;
            prev_sck = o_sck;
            if (o_rxv === 1'b1) begin
                valid_cnt++; valid_at = n; rx_at_valid = o_rxd;
            end else if (o_rxd !== prev_rx) begin
                hold_err++;
            end
            // Command input changes after acceptance must not matter.
            if (n == 0 && !hold) begin
                cur_start = 1'b0; cur_tx = 8'($urandom);
            end
            if (poke >= 0 && n == poke) begin
                cur_start = 1'b1; cur_tx = 8'hAA;
            end
            if (poke >= 0 && n == poke + 1) cur_start = 1'b0;
            // Slave: present bit `rises` of resp while selected, noise otherwise.
            mi = (o_ss === 1'b0 && rises < 8) ? resp[rises] : 1'($urandom);
            drive(sel, cur_start, cur_tx, mi);
        end
        if (!hold) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                o_ss   = (sel == 0) ? ss_a   : ss_b;
                o_busy = (sel == 0) ? busy_a : busy_b;
                o_rxd  = (sel == 0) ? rxd_a  : rxd_b;
                o_rxv  = (sel == 0) ? rxv_a  : rxv_b;
                if (o_ss !== 1'b1 || o_busy !== 1'b0 || o_rxv !== 1'b0 || o_rxd !== exp_rx) idle_err++;
            end
            check("idle_after_done", idle_err, 0);
        end
        check("mosi_bits", mosi_bits, exp_mosi);
        check("sck_rises", rises, 8);
        check("sck_falls", falls, 8);
        check("sck_rise_times", time_err, 0);
        check("sck_while_ss_high", sck_err, 0);
        check("ss_window", ss_err, 0);
        check("busy_window", busy_err, 0);
        check("rx_valid_count", valid_cnt, 1);
        check("rx_valid_cycle", valid_at, exp_done);
        check("rx_data", rx_at_valid, exp_rx);
        check("rx_data_held", hold_err, 0);
    endtask

    vec_t vecs[6];

    initial begin
        int rst_err, rises, sel;
        logic prev_sck;
        logic [7:0] tx, resp;

        vecs[0] = '{0, 8'h01, 8'h05, -1, 1'b0, 8'h01, 8'h05, 73};  // single transfer
        vecs[1] = '{0, 8'h01, 8'h05, 10, 1'b0, 8'h01, 8'h05, 73};  // busy lockout
        vecs[2] = '{0, 8'h3C, 8'hFF, -1, 1'b1, 8'h3C, 8'hFF, 73};  // back-to-back #1
        vecs[3] = '{0, 8'h3C, 8'h00, -1, 1'b0, 8'h3C, 8'h00, 73};  // back-to-back #2
        vecs[4] = '{1, 8'h80, 8'h09, -1, 1'b0, 8'h80, 8'h09, 37};  // CLK_DIV=2
        vecs[5] = '{1, 8'hA7, 8'h6C, 5, 1'b0, 8'hA7, 8'h6C, 37};   // CLK_DIV=2 lockout

        n_rst = 1'b0;
        start_a = 1'b0; start_b = 1'b0; tx_a = 8'h00; tx_b = 8'h00;
        miso_a = 1'b0; miso_b = 1'b0;

        // Reset held: outputs must stay at reset values while start toggles.
        rst_err = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (sck_a !== 1'b0 || ss_a !== 1'b1 || mosi_a !== 1'b0 || rxd_a !== 8'h00 ||
                rxv_a !== 1'b0 || busy_a !== 1'b0) rst_err++;
            if (sck_b !== 1'b0 || ss_b !== 1'b1 || mosi_b !== 1'b0 || rxd_b !== 8'h00 ||
                rxv_b !== 1'b0 || busy_b !== 1'b0) rst_err++;
            start_a = ~start_a; start_b = ~start_b;
            tx_a = 8'($urandom); tx_b = 8'($urandom);
            miso_a = 1'($urandom); miso_b = 1'($urandom);
        end
        check("reset_outputs", rst_err, 0);
        start_a = 1'b0; start_b = 1'b0;
        n_rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_reset_ss", ss_a, 1'b1);
        check("post_reset_busy", busy_a, 1'b0);

        // Directed table.
        for (int v = 0; v < 6; v++)
            xfer(vecs[v].sel, vecs[v].tx, vecs[v].resp, vecs[v].poke, vecs[v].hold,
                 vecs[v].exp_mosi, vecs[v].exp_rx, vecs[v].exp_done);

        // Reset mid-transfer: rx_data is 0x00 from the previous CLK_DIV=4 transfer.
        rises = 0;
        prev_sck = sck_a;
        start_a = 1'b1; tx_a = 8'h5A;
        for (int n = 0; n < 200 && rises < 4; n++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (sck_a === 1'b1 && prev_sck === 1'b0) rises++;
            prev_sck = sck_a;
            miso_a = 1'b1;
        end
        check("mid_rst_reached_rise4", rises, 4);
        n_rst = 1'b0;
        #1;
        check("mid_rst_ss", ss_a, 1'b1);
        check("mid_rst_sck", sck_a, 1'b0);
        check("mid_rst_busy", busy_a, 1'b0);
        check("mid_rst_rx_data", rxd_a, 8'h00);
        rst_err = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rxv_a !== 1'b0 || rxd_a !== 8'h00) rst_err++;
        end
        n_rst = 1'b1;
        @(negedge clk);
        check("mid_rst_no_valid", rst_err, 0);
        xfer(0, 8'hC3, 8'h96, -1, 1'b0, 8'hC3, 8'h96, 73);

        // Randomized transfers against the formula model.
        for (int r = 0; r < 6; r++) begin
            sel  = int'($urandom_range(0, 1));
            tx   = 8'($urandom);
            resp = 8'($urandom);
            xfer(sel, tx, resp, -1, 1'b0, tx, resp, 1 + 18 * ((sel == 0) ? 4 : 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
